// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state encoding, datapath select codes and opcodes for the multi-cycle control FSM
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_WB_MEM  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_I  = 4'd6,
    S_EXEC_R  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_BRANCH  = 4'd9,
    S_TRAP    = 4'd10
  } state_e;

  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - saturating memory-stall counter that flags when a request has waited LIMIT cycles
module mc_wait_timer #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // LIMIT of zero means the timeout is disabled entirely.
  assign expired = (LIMIT != 0) && (cnt_q == LIMIT_C);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle RV32I core with shared memory port
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       instr_done,
  output logic       trap
);

  state_e state_q, state_d;
  logic   waiting, expired, br_ok, taken, is_load;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign br_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign taken   = zero ^ funct3[0];
  assign is_load = (opcode == OP_LOAD);

  mc_wait_timer #(.LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .en      (waiting && !mem_ready),
    .expired (expired)
  );

  // A ready arriving in the expiry cycle still completes the transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE; else if (expired) state_d = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_IMM:            state_d = S_EXEC_I;
          OP_REG:            state_d = S_EXEC_R;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADDR: state_d = is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (mem_ready) state_d = S_WB_MEM; else if (expired) state_d = S_TRAP;
      S_WB_MEM:  state_d = S_FETCH;
      S_MEM_WR:  if (mem_ready) state_d = S_FETCH; else if (expired) state_d = S_TRAP;
      S_EXEC_I:  state_d = S_WB_ALU;
      S_EXEC_R:  state_d = S_WB_ALU;
      S_WB_ALU:  state_d = S_FETCH;
      S_BRANCH:  state_d = br_ok ? S_FETCH : S_TRAP;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    imm_sel    = IMM_NONE;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_sel   = IMM_B;
      end
      S_MEMADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_sel   = is_load ? IMM_I : IMM_S;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        wb_sel     = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        addr_sel   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_sel   = IMM_I;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_op     = ALU_SUB;
        pc_src     = 1'b1;
        pc_write   = br_ok && taken;
        instr_done = br_ok;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
    // Reset abandons any outstanding request, so nothing may strobe during it.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      trap       = 1'b0;
    end
  end

endmodule
